// File: rtl/column_buffer_ctrl.sv
// Sequencer for one post-processing column buffer used as a cfg_delay-column delay line.
// Accepts W columns per line, drains the SRAM pipeline tail and presents exactly W output columns.
//
//   state   | meaning
//   S_IDLE  | waiting for start; cfg checked and latched here
//   S_FILL  | input columns drive the beats
//   S_FLUSH | internal beats drain the delay line; waits for last output handshake
module column_buffer_ctrl #(
   parameter int AWIDTH = 9,
   parameter int DEPTH  = 512,
   parameter int LWIDTH = 11,
   parameter int PIPE   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LWIDTH-1:0] cfg_line_width,
   input  logic [AWIDTH-1:0] cfg_delay,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              buf_clken,
   output logic [AWIDTH-1:0] buf_rd_addr,
   output logic              busy,
   output logic              line_done,
   output logic              cfg_err
);

   localparam int BWIDTH = LWIDTH + 1;
   localparam logic [AWIDTH:0] D_MAX = (AWIDTH+1)'(DEPTH - 2);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;

   state_t            state, state_nxt;
   logic [LWIDTH-1:0] w_lat;
   logic [AWIDTH-1:0] d_lat;
   logic [BWIDTH-1:0] beat_cnt;
   logic [LWIDTH-1:0] out_cnt;
   logic [AWIDTH-1:0] wr_ptr, wr_ptr_nxt, rd_addr_nxt;
   logic [BWIDTH-1:0] beat_total, first_out_idx, fill_last_idx;
   logic              beat, adv_ok, hs, last_hs, cfg_ok, accept, reject, done;

   assign adv_ok        = !out_valid || out_ready;
   assign hs            = out_valid && out_ready;
   assign out_last      = out_valid && (out_cnt == w_lat - 1'b1);
   assign last_hs       = hs && out_last;
   assign busy          = (state != S_IDLE);
   assign buf_clken     = beat;
   assign cfg_ok        = (cfg_line_width != '0) && (cfg_delay != '0) && ({1'b0, cfg_delay} <= D_MAX);
   assign beat_total    = BWIDTH'(w_lat) + BWIDTH'(d_lat) + BWIDTH'(PIPE - 1);
   // beat_cnt holds beats already issued; the next beat is number beat_cnt+1
   assign first_out_idx = BWIDTH'(d_lat) + BWIDTH'(PIPE - 1);
   assign fill_last_idx = BWIDTH'(w_lat) - 1'b1;
   assign wr_ptr_nxt    = (wr_ptr == AWIDTH'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
   assign rd_addr_nxt   = (wr_ptr_nxt >= d_lat) ? (wr_ptr_nxt - d_lat)
                                                : AWIDTH'(int'(wr_ptr_nxt) + DEPTH - int'(d_lat));

   always_comb begin
      state_nxt = state;
      beat      = 1'b0;
      in_ready  = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  accept    = 1'b1;
                  state_nxt = S_FILL;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         S_FILL: begin
            in_ready = adv_ok;
            beat     = in_valid && adv_ok;
            if (beat && (beat_cnt == fill_last_idx)) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            beat = adv_ok && (beat_cnt != beat_total);
            if (last_hs) begin
               state_nxt = S_IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         w_lat       <= '0;
         d_lat       <= '0;
         beat_cnt    <= '0;
         out_cnt     <= '0;
         wr_ptr      <= '0;
         buf_rd_addr <= '0;
         out_valid   <= 1'b0;
         line_done   <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         state     <= state_nxt;
         line_done <= done;
         cfg_err   <= reject;
         if (accept) begin
            w_lat    <= cfg_line_width;
            d_lat    <= cfg_delay;
            beat_cnt <= '0;
            out_cnt  <= '0;
         end
         if (beat) begin
            beat_cnt    <= beat_cnt + 1'b1;
            wr_ptr      <= wr_ptr_nxt;
            buf_rd_addr <= rd_addr_nxt;
         end
         // a beat with a pending column implies a handshake, so the new column simply replaces it
         if (beat && (beat_cnt >= first_out_idx)) out_valid <= 1'b1;
         else if (hs)                            out_valid <= 1'b0;
         if (hs) out_cnt <= out_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_column_buffer_ctrl.sv
// Randomized bench for column_buffer_ctrl against a line-level reference model.
// The model counts beats/handshakes per line and derives every output from the delay-line rules.
module tb_column_buffer_ctrl;

   localparam int AWIDTH = 9;
   localparam int DEPTH  = 512;
   localparam int LWIDTH = 11;
   localparam int PIPE   = 2;
   localparam int LIMIT  = 20000;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [LWIDTH-1:0] cfg_line_width;
   logic [AWIDTH-1:0] cfg_delay;
   logic              in_valid;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              buf_clken;
   logic [AWIDTH-1:0] buf_rd_addr;
   logic              busy;
   logic              line_done;
   logic              cfg_err;

   int n_chk  = 0;
   int n_fail = 0;

   column_buffer_ctrl #(.AWIDTH(AWIDTH), .DEPTH(DEPTH), .LWIDTH(LWIDTH), .PIPE(PIPE)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_line_width(cfg_line_width), .cfg_delay(cfg_delay),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .buf_clken(buf_clken), .buf_rd_addr(buf_rd_addr), .busy(busy),
      .line_done(line_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: state after the most recent posedge
   int m_act, m_w, m_d, m_in, m_beats, m_hs, m_wp, m_rd, m_err, m_done;
   int total, avail, obs_hs, obs_last;
   bit e_ov, e_adv, e_ir, e_ck, e_last;

   always @(negedge clk) begin
      if (!rst) begin
         m_act = 0; m_in = 0; m_beats = 0; m_hs = 0; m_wp = 0; m_rd = 0; m_err = 0; m_done = 0;
         obs_hs = 0; obs_last = 0;
      end
      total = m_w + m_d + PIPE - 1;
      avail = (m_act != 0 && m_beats >= m_d + PIPE) ? m_beats - m_d - PIPE + 1 : 0;
      if (avail > m_w) avail = m_w;
      e_ov   = (avail > m_hs);
      e_adv  = !e_ov || out_ready;
      e_ir   = (m_act != 0) && (m_in < m_w) && e_adv;
      e_ck   = (m_act != 0) && ((m_in < m_w) ? (in_valid && e_adv) : (m_beats < total && e_adv));
      e_last = e_ov && (m_hs == m_w - 1);

      chk("busy",        busy,        m_act);
      chk("out_valid",   out_valid,   e_ov);
      chk("out_last",    out_last,    e_last);
      chk("in_ready",    in_ready,    e_ir);
      chk("buf_clken",   buf_clken,   e_ck);
      chk("buf_rd_addr", buf_rd_addr, m_rd);
      chk("cfg_err",     cfg_err,     m_err);
      chk("line_done",   line_done,   m_done);

      if (out_valid && out_ready) obs_hs++;
      if (out_valid && out_ready && out_last) obs_last++;
      if (line_done) begin
         chk("hs_per_line",   obs_hs,   m_w);
         chk("last_per_line", obs_last, 1);
         obs_hs = 0; obs_last = 0;
      end

      if (rst) begin
         m_err = 0; m_done = 0;
         if (m_act == 0) begin
            if (start) begin
               if (cfg_line_width != 0 && cfg_delay != 0 && int'(cfg_delay) <= DEPTH - 2) begin
                  m_act = 1; m_w = cfg_line_width; m_d = cfg_delay;
                  m_in = 0; m_beats = 0; m_hs = 0;
               end else begin
                  m_err = 1;
               end
            end
         end else begin
            if (e_ck) begin
               m_beats++;
               if (m_in < m_w) m_in++;
               m_wp = (m_wp + 1) % DEPTH;
               m_rd = (m_wp - m_d + DEPTH) % DEPTH;
            end
            if (e_ov && out_ready) begin
               m_hs++;
               if (m_hs == m_w) begin
                  m_act = 0; m_done = 1;
               end
            end
         end
      end
   end

   int stall_at   = -1;
   int stall_left = 0;
   bit stall_done = 0;

   task automatic drive_hs(input int pv, input int pr);
      in_valid  = ($urandom_range(99) < pv);
      out_ready = ($urandom_range(99) < pr);
      if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else if (stall_at >= 0 && !stall_done && m_hs == stall_at) begin
         out_ready  = 1'b0;
         stall_left = 2;
         stall_done = 1;
      end
   endtask

   task automatic run_line(input int w, input int d, input int pv, input int pr, input bit hold_start);
      int cyc;
      @(posedge clk); #1;
      start = 1'b1; cfg_line_width = LWIDTH'(w); cfg_delay = AWIDTH'(d);
      drive_hs(pv, pr);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         if (!hold_start) begin
            start          = 1'b0;
            cfg_line_width = LWIDTH'($urandom);
            cfg_delay      = AWIDTH'($urandom);
         end
         drive_hs(pv, pr);
         cyc++;
      end while (!line_done && cyc < LIMIT);
      if (cyc >= LIMIT) chk("line_timeout", 0, 1);
   endtask

   task automatic bad_cfg(input int w, input int d);
      @(posedge clk); #1;
      start = 1'b1; cfg_line_width = LWIDTH'(w); cfg_delay = AWIDTH'(d);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; cfg_line_width = '0; cfg_delay = '0;
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // reset mid-FILL
      @(posedge clk); #1;
      start = 1'b1; cfg_line_width = 20; cfg_delay = 4; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // basic line from wr_ptr 0
      run_line(8, 3, 100, 100, 1'b0);

      // land wr_ptr on 508, then a line that wraps the ring
      run_line(508 - m_wp - 3, 2, 100, 100, 1'b0);
      run_line(6, 2, 100, 100, 1'b0);

      // backpressure: out_ready low 3 cycles while column 2 is presented
      stall_at = 2; stall_done = 0;
      run_line(8, 3, 100, 100, 1'b0);
      stall_at = -1;

      bad_cfg(8, 0);
      bad_cfg(8, DEPTH - 1);
      bad_cfg(0, 3);

      // start held through line_done: next line accepted immediately
      run_line(8, 3, 80, 80, 1'b1);
      run_line(8, 3, 80, 80, 1'b0);

      // boundary delay and width 1
      run_line(1, DEPTH - 2, 100, 70, 1'b0);
      run_line(1, 1, 50, 50, 1'b0);

      for (int i = 0; i < 8; i++)
         run_line($urandom_range(1, 40), $urandom_range(1, 60), $urandom_range(30, 100),
                  $urandom_range(30, 100), 1'b0);

      in_valid = 1'b0; out_ready = 1'b0;
      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
